// File: rtl/uart_tx_buffered.sv
// Buffered 8N1/8E1/8O1 UART transmitter: host writes bytes into a FIFO and a
// baud-timed serializer drains it onto tx with no idle gap between queued frames.
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int FIFO_DEPTH   = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_enb,
    input  logic [7:0]                    data_in,
    output logic                          tx,
    output logic                          busy,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic             ODD_BIT    = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic             full_q;
    logic             empty_q;
    logic             overflow_q;

    state_t           state_q;
    logic [CNT_W-1:0] baud_cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             parity_q;
    logic             tx_q;
    logic             busy_q;

    logic             wr_accept;
    logic             baud_done;
    logic             pop;

    // Acceptance uses the registered full flag, so a same-cycle pop never rescues a write.
    assign wr_accept = wr_enb && !full_q;
    assign baud_done = (baud_cnt_q == BAUD_LAST);
    assign pop       = !empty_q && ((state_q == IDLE) || (state_q == STOP && baud_done));

    always_comb begin
        count_d = count_q;
        if (wr_accept && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!wr_accept && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q    <= count_d;
            full_q     <= (count_d == FULL_COUNT);
            empty_q    <= (count_d == '0);
            overflow_q <= wr_enb && full_q;
        end
    end

    // Storage carries no reset so it can map onto RAM; stale entries are unreachable.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else if (state_q == IDLE) begin
            baud_cnt_q <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            if (pop) begin
                shift_q   <= mem_q[rd_ptr_q];
                parity_q  <= (^mem_q[rd_ptr_q]) ^ ODD_BIT;
                bit_idx_q <= '0;
                state_q   <= START;
                tx_q      <= 1'b0;
                busy_q    <= 1'b1;
            end
        end else if (!baud_done) begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
        end else begin
            baud_cnt_q <= '0;
            // tx is registered, so each branch drives the level of the state being entered.
            case (state_q)
                START: begin
                    state_q <= DATA;
                    tx_q    <= shift_q[0];
                end
                DATA: begin
                    shift_q <= shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
                        if (PARITY_EN != 0) begin
                            state_q <= PARITY;
                            tx_q    <= parity_q;
                        end else begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        bit_idx_q <= bit_idx_q + 1'b1;
                        tx_q      <= shift_q[1];
                    end
                end
                PARITY: begin
                    state_q <= STOP;
                    tx_q    <= 1'b1;
                end
                STOP: begin
                    if (pop) begin
                        shift_q   <= mem_q[rd_ptr_q];
                        parity_q  <= (^mem_q[rd_ptr_q]) ^ ODD_BIT;
                        bit_idx_q <= '0;
                        state_q   <= START;
                        tx_q      <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        tx_q    <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: directed writes feed an expected-byte queue that a
// line-decoding monitor drains; parity framing is checked on two extra instances.
module tb_uart_tx_buffered;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_enb = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       wr_enb_p = 1'b0;
    logic [7:0] data_in_p = 8'h00;

    logic       tx, busy, full, empty, overflow;
    logic [3:0] fifo_count;
    logic       tx_e, busy_e, full_e, empty_e, overflow_e;
    logic [3:0] fifo_count_e;
    logic       tx_o, busy_o, full_o, empty_o, overflow_o;
    logic [3:0] fifo_count_o;

    uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY_EN(0), .PARITY_ODD(0)) dut (
        .clk(clk), .rst(rst), .wr_enb(wr_enb), .data_in(data_in),
        .tx(tx), .busy(busy), .full(full), .empty(empty),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY_EN(1), .PARITY_ODD(0)) dut_even (
        .clk(clk), .rst(rst), .wr_enb(wr_enb_p), .data_in(data_in_p),
        .tx(tx_e), .busy(busy_e), .full(full_e), .empty(empty_e),
        .fifo_count(fifo_count_e), .overflow(overflow_e)
    );

    uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY_EN(1), .PARITY_ODD(1)) dut_odd (
        .clk(clk), .rst(rst), .wr_enb(wr_enb_p), .data_in(data_in_p),
        .tx(tx_o), .busy(busy_o), .full(full_o), .empty(empty_o),
        .fifo_count(fifo_count_o), .overflow(overflow_o)
    );

    always #5 clk = ~clk;

    int pass_cnt    = 0;
    int total_cnt   = 0;
    int frames_seen = 0;
    int busy_cycles = 0;
    int busy_rises  = 0;
    int ovf_pulses  = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Activity counters on dut, sampled mid-cycle.
    initial begin : activity
        logic busy_prev;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (busy === 1'b1) busy_cycles++;
            if (busy === 1'b1 && busy_prev !== 1'b1) busy_rises++;
            if (overflow === 1'b1) ovf_pulses++;
            busy_prev = busy;
        end
    end

    // Line receiver: finds a start bit, samples each bit at its centre, scores the byte.
    initial begin : monitor
        logic [7:0] byte_v;
        logic       aborted;
        logic       start_bit;
        logic       stop_bit;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && tx === 1'b0) begin
                aborted = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    if (rst !== 1'b1) aborted = 1'b1;
                end
                start_bit = tx;
                for (int b = 0; b < 8; b++) begin
                    repeat (CPB) begin
                        @(negedge clk);
                        if (rst !== 1'b1) aborted = 1'b1;
                    end
                    byte_v[b] = tx;
                end
                repeat (CPB) begin
                    @(negedge clk);
                    if (rst !== 1'b1) aborted = 1'b1;
                end
                stop_bit = tx;
                if (!aborted) begin
                    check("start_bit", 32'(start_bit), 32'd0);
                    check("stop_bit", 32'(stop_bit), 32'd1);
                    check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        check("rx_byte", 32'(byte_v), 32'(exp_q.pop_front()));
                    end
                    frames_seen++;
                end
            end
        end
    end

    // Drives one write for one cycle; call just after a falling edge.
    task automatic wr(input logic [7:0] v, input bit expect_accept);
        wr_enb  = 1'b1;
        data_in = v;
        if (expect_accept) exp_q.push_back(v);
        @(negedge clk);
        wr_enb  = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (!(busy === 1'b0 && empty === 1'b1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle_in_time"}, 32'(n < budget), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int f0, b0, r0, o0, peak;
        logic [10:0] frame_e, frame_o;
        int blen_e, blen_o;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte 0xA5: latency and frame length
        b0 = busy_cycles;
        wr(8'hA5, 1'b1);
        check("a5_empty_n1", 32'(empty), 32'd0);
        check("a5_tx_n1", 32'(tx), 32'd1);
        @(negedge clk);
        check("a5_tx_n2", 32'(tx), 32'd0);
        check("a5_busy_n2", 32'(busy), 32'd1);
        wait_idle("a5", 200);
        check("a5_busy_len", 32'(busy_cycles - b0), 32'd40);
        check("a5_empty_after", 32'(empty), 32'd1);

        // Three back-to-back frames
        b0 = busy_cycles;
        r0 = busy_rises;
        peak = 0;
        wr(8'h00, 1'b1);
        if (int'(fifo_count) > peak) peak = int'(fifo_count);
        wr(8'hFF, 1'b1);
        if (int'(fifo_count) > peak) peak = int'(fifo_count);
        wr(8'h3C, 1'b1);
        if (int'(fifo_count) > peak) peak = int'(fifo_count);
        check("b2b_peak_2_or_3", 32'(peak >= 2 && peak <= 3), 32'd1);
        wait_idle("b2b", 400);
        check("b2b_busy_len", 32'(busy_cycles - b0), 32'd120);
        check("b2b_no_gap", 32'(busy_rises - r0), 32'd1);

        // Overflow: ten writes, nine accepted
        f0 = frames_seen;
        o0 = ovf_pulses;
        b0 = busy_cycles;
        for (int i = 0; i < 10; i++) begin
            wr(8'(8'h10 + i), i < 9);
        end
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_count", 32'(fifo_count), 32'd8);
        check("ovf_pulse", 32'(overflow), 32'd1);
        @(negedge clk);
        check("ovf_pulse_end", 32'(overflow), 32'd0);
        wait_idle("ovf", 1000);
        check("ovf_frames", 32'(frames_seen - f0), 32'd9);
        check("ovf_pulse_count", 32'(ovf_pulses - o0), 32'd1);
        check("ovf_busy_len", 32'(busy_cycles - b0), 32'd360);

        // Parity framing on 0x07: even -> parity 1, odd -> parity 0
        wr_enb_p  = 1'b1;
        data_in_p = 8'h07;
        @(negedge clk);
        wr_enb_p  = 1'b0;
        @(negedge clk);
        frame_e = '0;
        frame_o = '0;
        blen_e  = 0;
        blen_o  = 0;
        for (int i = 0; i < 50; i++) begin
            if (i < 44 && (i % CPB) == 2) begin
                frame_e[i / CPB] = tx_e;
                frame_o[i / CPB] = tx_o;
            end
            if (busy_e === 1'b1) blen_e++;
            if (busy_o === 1'b1) blen_o++;
            @(negedge clk);
        end
        check("par_even_frame", 32'(frame_e), 32'(11'b11000001110));
        check("par_odd_frame", 32'(frame_o), 32'(11'b10000001110));
        check("par_even_len", 32'(blen_e), 32'd44);
        check("par_odd_len", 32'(blen_o), 32'd44);

        // Reset in the middle of DATA with three bytes queued
        f0 = frames_seen;
        wr(8'h00, 1'b0);
        wr(8'h11, 1'b0);
        wr(8'h22, 1'b0);
        wr(8'h33, 1'b0);
        repeat (6) @(negedge clk);
        check("mid_tx_low", 32'(tx), 32'd0);
        check("mid_queued", 32'(fifo_count), 32'd3);
        #2;
        rst = 1'b0;
        #1;
        check("arst_tx", 32'(tx), 32'd1);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_empty", 32'(empty), 32'd1);
        check("arst_count", 32'(fifo_count), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        r0 = busy_rises;
        repeat (60) @(negedge clk);
        check("post_rst_quiet", 32'(busy_rises - r0), 32'd0);
        check("post_rst_tx", 32'(tx), 32'd1);
        check("post_rst_frames", 32'(frames_seen - f0), 32'd0);

        // Loopback-style decode of two bytes
        f0 = frames_seen;
        wr(8'h5A, 1'b1);
        wr(8'hC3, 1'b1);
        wait_idle("loop", 400);
        check("loop_frames", 32'(frames_seen - f0), 32'd2);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
